// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU definitions: ALU opcodes, major opcodes, architectural register
// indices and the packed decoder control bundle carried down the pipeline.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

    // ALU operation codes
    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_AND = 5'b00010;
    localparam logic [4:0] ALU_OR  = 5'b00011;
    localparam logic [4:0] ALU_SLL = 5'b00100;
    localparam logic [4:0] ALU_SRA = 5'b00101;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    // Major opcodes
    localparam logic [4:0] OP_SW  = 5'b00111;
    localparam logic [4:0] OP_LW  = 5'b01000;
    localparam logic [4:0] OP_JAL = 5'b00011;

    // Architectural registers with fixed roles
    localparam int REG_RA      = 31;
    localparam int REG_RSTATUS = 30;

    // Decoder control bundle; field order is also the bit order (Rwe = MSB)
    typedef struct packed {
        logic Rwe;
        logic br;
        logic DMwe;
        logic ALUinB;
        logic Rwd;
        logic j;
        logic jr;
        logic jal;
    } ctrl_t;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use hazard and stall-request logic.
// Ports:
//   i_ex_valid, i_ex_Rwd, i_ex_wreg : instruction currently in EX
//   i_id_valid, i_id_rs, i_id_rt,
//   i_id_rt_used                     : instruction currently in ID
//   i_ex_busy                        : multi-cycle unit in EX not done
//   o_hz                             : load-use hazard
//   o_stall_id                       : freeze PC and IF/ID this cycle
// -----------------------------------------------------------------------------
module hazard_detect
    import cpu_pkg::*;
#(
    parameter int RW = 5
) (
    input  logic          i_ex_valid,
    input  logic          i_ex_Rwd,
    input  logic [RW-1:0] i_ex_wreg,
    input  logic          i_id_valid,
    input  logic [RW-1:0] i_id_rs,
    input  logic [RW-1:0] i_id_rt,
    input  logic          i_id_rt_used,
    input  logic          i_ex_busy,
    output logic          o_hz,
    output logic          o_stall_id
);

    logic w_rs_match;
    logic w_rt_match;

    assign w_rs_match = (i_id_rs == i_ex_wreg);
    // rt only matters when the ID instruction actually reads it (e.g. not addi)
    assign w_rt_match = i_id_rt_used && (i_id_rt == i_ex_wreg);

    // r0 is hardwired zero, so a load targeting it can never be a hazard source
    assign o_hz = i_ex_valid && i_ex_Rwd && (i_ex_wreg != '0) && i_id_valid
                  && (w_rs_match || w_rt_match);

    assign o_stall_id = o_hz || i_ex_busy;

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// Decode-to-execute pipeline register. Captures the decoder control bundle,
// operands and destination for EX; inserts bubbles on load-use hazards and
// flushes; holds while the mul/div unit is busy; raises the stall request that
// freezes PC and IF/ID; counts stall cycles (saturating).
// Ports:
//   i_clock, i_reset_n              : clock, async active-low reset
//   i_id_*                          : ID-stage instruction, operands, controls
//   i_ex_busy                       : mul/div in EX not finished
//   i_flush                         : kill the instruction leaving ID
//   o_ex_*                          : registered EX-stage copies
//   o_stall_id                      : combinational stall request
//   o_stall_count                   : saturating stall-cycle counter
// -----------------------------------------------------------------------------
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5,
    parameter int CW = 16
) (
    input  logic          i_clock,
    input  logic          i_reset_n,
    input  logic          i_id_valid,
    input  logic [DW-1:0] i_id_pc,
    input  logic [DW-1:0] i_id_imm,
    input  logic [DW-1:0] i_id_rs_data,
    input  logic [DW-1:0] i_id_rt_data,
    input  logic [RW-1:0] i_id_rs,
    input  logic [RW-1:0] i_id_rt,
    input  logic          i_id_rt_used,
    input  logic [RW-1:0] i_id_rd,
    input  logic [4:0]    i_id_alu_op,
    input  logic          i_id_Rwe,
    input  logic          i_id_br,
    input  logic          i_id_DMwe,
    input  logic          i_id_ALUinB,
    input  logic          i_id_Rwd,
    input  logic          i_id_j,
    input  logic          i_id_jr,
    input  logic          i_id_jal,
    input  logic          i_ex_busy,
    input  logic          i_flush,
    output logic          o_ex_valid,
    output logic [DW-1:0] o_ex_pc,
    output logic [DW-1:0] o_ex_imm,
    output logic [DW-1:0] o_ex_rs_data,
    output logic [DW-1:0] o_ex_rt_data,
    output logic [RW-1:0] o_ex_wreg,
    output logic [4:0]    o_ex_alu_op,
    output logic          o_ex_Rwe,
    output logic          o_ex_br,
    output logic          o_ex_DMwe,
    output logic          o_ex_ALUinB,
    output logic          o_ex_Rwd,
    output logic          o_ex_j,
    output logic          o_ex_jr,
    output logic          o_ex_jal,
    output logic          o_stall_id,
    output logic [CW-1:0] o_stall_count
);

    logic          r_ex_valid;
    ctrl_t         r_ctrl;
    logic [4:0]    r_alu_op;
    logic [DW-1:0] r_pc;
    logic [DW-1:0] r_imm;
    logic [DW-1:0] r_rs_data;
    logic [DW-1:0] r_rt_data;
    logic [RW-1:0] r_wreg;
    logic          r_flush_pending;
    logic [CW-1:0] r_stall_count;

    ctrl_t         w_id_ctrl;
    ctrl_t         w_id_ctrl_gated;
    logic [RW-1:0] w_id_wreg;
    logic          w_hz;
    logic          w_stall_id;

    always_comb begin
        w_id_ctrl = '{Rwe:    i_id_Rwe,
                      br:     i_id_br,
                      DMwe:   i_id_DMwe,
                      ALUinB: i_id_ALUinB,
                      Rwd:    i_id_Rwd,
                      j:      i_id_j,
                      jr:     i_id_jr,
                      jal:    i_id_jal};
        // An invalid ID slot must never carry live controls into EX
        w_id_ctrl_gated = i_id_valid ? w_id_ctrl : ctrl_t'('0);
        // jal links into the return-address register regardless of rd
        w_id_wreg = i_id_jal ? RW'(REG_RA) : i_id_rd;
    end

    hazard_detect #(
        .RW(RW)
    ) u_hazard_detect (
        .i_ex_valid   (r_ex_valid),
        .i_ex_Rwd     (r_ctrl.Rwd),
        .i_ex_wreg    (r_wreg),
        .i_id_valid   (i_id_valid),
        .i_id_rs      (i_id_rs),
        .i_id_rt      (i_id_rt),
        .i_id_rt_used (i_id_rt_used),
        .i_ex_busy    (i_ex_busy),
        .o_hz         (w_hz),
        .o_stall_id   (w_stall_id)
    );

    // Pipeline register. Priority: hold on busy > flush bubble > hazard bubble > load.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ex_valid      <= 1'b0;
            r_ctrl          <= '0;
            r_alu_op        <= '0;
            r_pc            <= '0;
            r_imm           <= '0;
            r_rs_data       <= '0;
            r_rt_data       <= '0;
            r_wreg          <= '0;
            r_flush_pending <= 1'b0;
        end else if (i_ex_busy) begin
            // EX is frozen; remember a flush so it is honoured once busy drops.
            // A single bit is enough: repeated flushes collapse into one bubble.
            if (i_flush) begin
                r_flush_pending <= 1'b1;
            end
        end else if (i_flush || r_flush_pending || w_hz) begin
            // Bubble: only valid/controls/opcode are cleared, data fields hold
            r_ex_valid      <= 1'b0;
            r_ctrl          <= '0;
            r_alu_op        <= '0;
            r_flush_pending <= 1'b0;
        end else begin
            r_ex_valid <= i_id_valid;
            r_ctrl     <= w_id_ctrl_gated;
            r_alu_op   <= i_id_alu_op;
            r_pc       <= i_id_pc;
            r_imm      <= i_id_imm;
            r_rs_data  <= i_id_rs_data;
            r_rt_data  <= i_id_rt_data;
            r_wreg     <= w_id_wreg;
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_stall_count <= '0;
        end else if (w_stall_id && (r_stall_count != {CW{1'b1}})) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign o_ex_valid    = r_ex_valid;
    assign o_ex_pc       = r_pc;
    assign o_ex_imm      = r_imm;
    assign o_ex_rs_data  = r_rs_data;
    assign o_ex_rt_data  = r_rt_data;
    assign o_ex_wreg     = r_wreg;
    assign o_ex_alu_op   = r_alu_op;
    assign o_ex_Rwe      = r_ctrl.Rwe;
    assign o_ex_br       = r_ctrl.br;
    assign o_ex_DMwe     = r_ctrl.DMwe;
    assign o_ex_ALUinB   = r_ctrl.ALUinB;
    assign o_ex_Rwd      = r_ctrl.Rwd;
    assign o_ex_j        = r_ctrl.j;
    assign o_ex_jr       = r_ctrl.jr;
    assign o_ex_jal      = r_ctrl.jal;
    assign o_stall_id    = w_stall_id;
    assign o_stall_count = r_stall_count;

endmodule
